// File: rtl/signal_conditioner_pkg.sv
// signal_conditioner_pkg: shared state encoding, glitch counter width and default parameters
package signal_conditioner_pkg;
  typedef enum logic [1:0] {ST_LOW, ST_RISE_QUAL, ST_HIGH, ST_FALL_QUAL} cond_state_t;
  localparam int GLITCH_CNT_W = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 64;
  localparam logic DEF_INIT_LEVEL = 1'b0;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flip-flop synchronizer for an asynchronous field input
// ports: clock, reset (sync active-low, loads INIT), d (async in), q (synchronized out)
module sync_chain #(
  parameter int STAGES = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clock)
    if (!reset) r_sync <= {STAGES{INIT}};
    else r_sync <= {r_sync[STAGES-2:0], d};
  assign q = r_sync[STAGES-1];
endmodule

// File: rtl/signal_conditioner.sv
// signal_conditioner: synchronizes and debounces a bouncing field input, emits edge strobes and counts rejected glitches
// ports: clock, reset (sync active-low), raw_in (async), enable (strobe gate),
//        level (debounced level), rise_pulse/fall_pulse (one-cycle strobes), glitch_count (saturating)
module signal_conditioner
  import signal_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic INIT_LEVEL = DEF_INIT_LEVEL
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    raw_in,
  input  logic                    enable,
  output logic                    level,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic [GLITCH_CNT_W-1:0] glitch_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] QUAL_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam cond_state_t RST_STATE = INIT_LEVEL ? ST_HIGH : ST_LOW;
  logic w_sync;
  cond_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic w_abort;
  logic [GLITCH_CNT_W-1:0] r_glitch, w_glitch_nxt;
  logic r_level, r_rise, r_fall, r_en;
  logic w_hi, w_rise_nxt, w_fall_nxt;
  sync_chain #(.STAGES(SYNC_STAGES), .INIT(INIT_LEVEL)) u_sync (
    .clock(clock),
    .reset(reset),
    .d(raw_in),
    .q(w_sync)
  );
  always_ff @(posedge clock)
    if (!reset) begin
      r_state  <= RST_STATE;
      r_cnt    <= '0;
      r_glitch <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_glitch <= w_glitch_nxt;
    end
  // counter is zero outside the qualifying states; reaching QUAL_LAST with the sample still
  // agreeing means DEBOUNCE_CYCLES consecutive matching samples have been seen
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_abort     = 1'b0;
    case (r_state)
      ST_LOW:       if (w_sync) begin w_state_nxt = ST_RISE_QUAL; w_cnt_nxt = CW'(1); end
      ST_RISE_QUAL: if (!w_sync) begin w_state_nxt = ST_LOW; w_abort = 1'b1; end
                    else if (r_cnt == QUAL_LAST) w_state_nxt = ST_HIGH;
                    else w_cnt_nxt = r_cnt + 1'b1;
      ST_HIGH:      if (!w_sync) begin w_state_nxt = ST_FALL_QUAL; w_cnt_nxt = CW'(1); end
      ST_FALL_QUAL: if (w_sync) begin w_state_nxt = ST_HIGH; w_abort = 1'b1; end
                    else if (r_cnt == QUAL_LAST) w_state_nxt = ST_LOW;
                    else w_cnt_nxt = r_cnt + 1'b1;
      default:      w_state_nxt = RST_STATE;
    endcase
    w_glitch_nxt = (w_abort && r_glitch != '1) ? r_glitch + 1'b1 : r_glitch;
  end
  // outputs trail the state by one register; a strobe fires when the state side has crossed
  // but the registered level has not, gated by enable captured on the transition cycle
  always_comb begin
    w_hi       = (r_state == ST_HIGH) || (r_state == ST_FALL_QUAL);
    w_rise_nxt = r_en && (r_state == ST_HIGH) && !r_level;
    w_fall_nxt = r_en && (r_state == ST_LOW) && r_level;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      r_level <= INIT_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_level <= w_hi;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_en    <= enable;
    end
  assign level        = r_level;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign glitch_count = r_glitch;
endmodule
